// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage of a 5-stage RV32 subset pipeline.
//   * 32x32 register file with a write port driven from WB (x0 hard-wired 0)
//   * decoder for R-ALU, I-ALU, LW, SW, BEQ/BNE, JAL, LUI (anything else = bubble)
//   * load-use hazard detection (Stall_IF) and flush handling (PCSrc_EX)
//   * ID/EX pipeline register driving all *_IDEX outputs
// Configuration macro:
//   WB_BYPASS_EN  defined   -> a WB write to rs1/rs2 in the same cycle is
//                              forwarded into the captured RD1/RD2
//                 undefined -> RD1/RD2 capture the pre-write register content
// -----------------------------------------------------------------------------
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruc_IFID,
  input  logic [31:0] PC_IFID,
  input  logic        RegWrite_WB,
  input  logic [4:0]  Rd_WB,
  input  logic [31:0] Result_WB,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rd_EX,
  input  logic        PCSrc_EX,
  output logic        Stall_IF,
  output logic [31:0] PC_IDEX,
  output logic [31:0] RD1_IDEX,
  output logic [31:0] RD2_IDEX,
  output logic [31:0] Imm_IDEX,
  output logic [4:0]  Rs1_IDEX,
  output logic [4:0]  Rs2_IDEX,
  output logic [4:0]  Rd_IDEX,
  output logic [3:0]  ALUCtrl_IDEX,
  output logic        ALUSrc_IDEX,
  output logic        MemRead_IDEX,
  output logic        MemWrite_IDEX,
  output logic        RegWrite_IDEX,
  output logic        MemToReg_IDEX,
  output logic        Branch_IDEX,
  output logic        Jump_IDEX
);

  typedef enum logic [6:0] {
    OP_R_ALU = 7'b0110011,
    OP_I_ALU = 7'b0010011,
    OP_LW    = 7'b0000011,
    OP_SW    = 7'b0100011,
    OP_BR    = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_LUI   = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  // Everything the ID/EX register carries; an all-zero value is a bubble.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } idex_t;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign opcode    = Instruc_IFID[6:0];
  assign funct3    = Instruc_IFID[14:12];
  assign funct7_b5 = Instruc_IFID[30];
  assign rs1_idx   = Instruc_IFID[19:15];
  assign rs2_idx   = Instruc_IFID[24:20];
  assign rd_idx    = Instruc_IFID[11:7];

  assign imm_i = {{20{Instruc_IFID[31]}}, Instruc_IFID[31:20]};
  assign imm_s = {{20{Instruc_IFID[31]}}, Instruc_IFID[31:25], Instruc_IFID[11:7]};
  assign imm_b = {{19{Instruc_IFID[31]}}, Instruc_IFID[31], Instruc_IFID[7],
                  Instruc_IFID[30:25], Instruc_IFID[11:8], 1'b0};
  assign imm_j = {{11{Instruc_IFID[31]}}, Instruc_IFID[31], Instruc_IFID[19:12],
                  Instruc_IFID[20], Instruc_IFID[30:21], 1'b0};
  assign imm_u = {Instruc_IFID[31:12], 12'b0};

  // Register file storage
  logic [31:0] rf_q [32];
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;

  // Decoder outputs
  idex_t dec;
  logic  valid;
  logic  uses_rs1;
  logic  uses_rs2;
  logic  bubble;
  idex_t idex_d;
  idex_t idex_q;

  // Register file: write from WB on the rising edge; x0 is never written.
  // NOTE: the register array is reset explicitly because every register must
  // read 0 after reset; most RAMs are left unreset, this one is flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWrite_WB && (Rd_WB != 5'd0)) begin
      rf_q[Rd_WB] <= Result_WB;
    end
  end

  // Register file read ports (x0 reads 0), with optional WB write-through.
  always_comb begin
    rf_rd1 = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx];
    rf_rd2 = (rs2_idx == 5'd0) ? 32'd0 : rf_q[rs2_idx];
`ifdef WB_BYPASS_EN
    if (RegWrite_WB && (Rd_WB != 5'd0) && (Rd_WB == rs1_idx)) rf_rd1 = Result_WB;
    if (RegWrite_WB && (Rd_WB != 5'd0) && (Rd_WB == rs2_idx)) rf_rd2 = Result_WB;
`endif
  end

  // Main decoder: control bits, immediate and which sources are really read.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec      = '0;
    valid    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP_R_ALU: begin
        valid         = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.reg_write = 1'b1;
        unique case (funct3)
          3'b000:  dec.alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_ctrl = ALU_SLL;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b101:  dec.alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OP_I_ALU: begin
        valid         = 1'b1;
        uses_rs1      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        unique case (funct3)
          3'b000:  dec.alu_ctrl = ALU_ADD;   // no SUBI: bit 30 belongs to the immediate
          3'b001:  dec.alu_ctrl = ALU_SLL;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b101:  dec.alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_ctrl = ALU_OR;
          default: dec.alu_ctrl = ALU_AND;
        endcase
      end
      OP_LW: begin
        valid          = 1'b1;
        uses_rs1       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = imm_i;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        valid         = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_BR: begin
        valid        = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        dec.branch   = 1'b1;
        dec.imm      = imm_b;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        valid         = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_j;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_LUI: begin
        valid         = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
        dec.alu_ctrl  = ALU_PASSB;
      end
      default: ;
    endcase
    // Unused indices/data are zeroed so EX forwarding never matches on them.
    dec.pc  = valid ? PC_IFID : 32'd0;
    dec.rs1 = uses_rs1 ? rs1_idx : 5'd0;
    dec.rs2 = uses_rs2 ? rs2_idx : 5'd0;
    dec.rd1 = uses_rs1 ? rf_rd1 : 32'd0;
    dec.rd2 = uses_rs2 ? rf_rd2 : 32'd0;
    dec.rd  = dec.reg_write ? rd_idx : 5'd0;
  end

  // Load-use hazard; a flush overrides it and reset holds it low.
  assign Stall_IF = rst_n && !PCSrc_EX && MemRead_EX && (Rd_EX != 5'd0) &&
                    ((uses_rs1 && (Rd_EX == rs1_idx)) ||
                     (uses_rs2 && (Rd_EX == rs2_idx)));

  assign bubble = PCSrc_EX || Stall_IF;
  assign idex_d = bubble ? '0 : dec;

  // ID/EX pipeline register: loads every cycle, bubble on stall or flush.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign PC_IDEX       = idex_q.pc;
  assign RD1_IDEX      = idex_q.rd1;
  assign RD2_IDEX      = idex_q.rd2;
  assign Imm_IDEX      = idex_q.imm;
  assign Rs1_IDEX      = idex_q.rs1;
  assign Rs2_IDEX      = idex_q.rs2;
  assign Rd_IDEX       = idex_q.rd;
  assign ALUCtrl_IDEX  = idex_q.alu_ctrl;
  assign ALUSrc_IDEX   = idex_q.alu_src;
  assign MemRead_IDEX  = idex_q.mem_read;
  assign MemWrite_IDEX = idex_q.mem_write;
  assign RegWrite_IDEX = idex_q.reg_write;
  assign MemToReg_IDEX = idex_q.mem_to_reg;
  assign Branch_IDEX   = idex_q.branch;
  assign Jump_IDEX     = idex_q.jump;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed, table-driven bench for id_stage, plus hand-written
// sequences for WB write-through and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instruc_IFID, PC_IFID, Result_WB;
  logic        RegWrite_WB, MemRead_EX, PCSrc_EX;
  logic [4:0]  Rd_WB, Rd_EX;
  logic        Stall_IF;
  logic [31:0] PC_IDEX, RD1_IDEX, RD2_IDEX, Imm_IDEX;
  logic [4:0]  Rs1_IDEX, Rs2_IDEX, Rd_IDEX;
  logic [3:0]  ALUCtrl_IDEX;
  logic        ALUSrc_IDEX, MemRead_IDEX, MemWrite_IDEX, RegWrite_IDEX;
  logic        MemToReg_IDEX, Branch_IDEX, Jump_IDEX;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .Instruc_IFID(Instruc_IFID), .PC_IFID(PC_IFID),
    .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB), .Result_WB(Result_WB),
    .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX), .PCSrc_EX(PCSrc_EX),
    .Stall_IF(Stall_IF),
    .PC_IDEX(PC_IDEX), .RD1_IDEX(RD1_IDEX), .RD2_IDEX(RD2_IDEX), .Imm_IDEX(Imm_IDEX),
    .Rs1_IDEX(Rs1_IDEX), .Rs2_IDEX(Rs2_IDEX), .Rd_IDEX(Rd_IDEX),
    .ALUCtrl_IDEX(ALUCtrl_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .MemToReg_IDEX(MemToReg_IDEX),
    .Branch_IDEX(Branch_IDEX), .Jump_IDEX(Jump_IDEX)
  );

  // Control bundle order: {ALUCtrl[3:0], ALUSrc, MemRead, MemWrite, RegWrite, MemToReg, Branch, Jump}
  localparam logic [10:0] C_NONE = 11'b0000_0000000;
  localparam logic [10:0] C_ADDI = 11'b0000_1001000;
  localparam logic [10:0] C_SRAI = 11'b0111_1001000;
  localparam logic [10:0] C_LUI  = 11'b1010_1001000;
  localparam logic [10:0] C_SW   = 11'b0000_1010000;
  localparam logic [10:0] C_ADD  = 11'b0000_0001000;
  localparam logic [10:0] C_SUB  = 11'b0001_0001000;
  localparam logic [10:0] C_BEQ  = 11'b0001_0000010;
  localparam logic [10:0] C_JAL  = 11'b0000_0001001;
  localparam logic [10:0] C_LW   = 11'b0000_1101100;

  localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LUI        = 32'h1234_5437;  // lui  x8,0x12345
  localparam logic [31:0] I_SW         = 32'h0030_A423;  // sw   x3,8(x1)
  localparam logic [31:0] I_ADD        = 32'h0021_8233;  // add  x4,x3,x2
  localparam logic [31:0] I_SUB        = 32'h4021_84B3;  // sub  x9,x3,x2
  localparam logic [31:0] I_BEQ_M8     = 32'hFE00_0CE3;  // beq  x0,x0,-8
  localparam logic [31:0] I_BAD        = 32'h0001_807F;  // opcode 0x7F, rs1 field = 3
  localparam logic [31:0] I_JAL        = 32'h0100_00EF;  // jal  x1,+16
  localparam logic [31:0] I_SRAI       = 32'h4041_D513;  // srai x10,x3,4
  localparam logic [31:0] I_LW         = 32'hFFC1_2583;  // lw   x11,-4(x2)
  localparam logic [31:0] I_ADDI_X7_X0 = 32'h0000_0393;  // addi x7,x0,0
  localparam logic [31:0] I_ADDI_X6_X5 = 32'h0002_8313;  // addi x6,x5,0

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_read_ex;
    logic [4:0]  rd_ex;
    logic        pcsrc;
    logic        exp_stall;
    logic        exp_bubble;
    logic [10:0] exp_ctrl;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rs1, exp_rs2, exp_rd;
    logic [31:0] exp_rd1, exp_rd2;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctrl_now();
    return {ALUCtrl_IDEX, ALUSrc_IDEX, MemRead_IDEX, MemWrite_IDEX,
            RegWrite_IDEX, MemToReg_IDEX, Branch_IDEX, Jump_IDEX};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] instr, input logic wb_en, input logic [4:0] wb_rd,
    input logic [31:0] wb_data, input logic mr, input logic [4:0] rd_ex,
    input logic pcsrc, input logic stall, input logic bub, input logic [10:0] ctrl,
    input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2);
    vec_t v;
    v.instr = instr; v.pc = 32'h0; v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.mem_read_ex = mr; v.rd_ex = rd_ex; v.pcsrc = pcsrc; v.exp_stall = stall;
    v.exp_bubble = bub; v.exp_ctrl = ctrl; v.exp_imm = imm; v.exp_rs1 = rs1;
    v.exp_rs2 = rs2; v.exp_rd = rd; v.exp_rd1 = rd1; v.exp_rd2 = rd2;
    return v;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                       input logic mr, input logic [4:0] rd_ex, input logic pcsrc);
    Instruc_IFID = instr; PC_IFID = pc;
    RegWrite_WB = wb_en; Rd_WB = wb_rd; Result_WB = wb_data;
    MemRead_EX = mr; Rd_EX = rd_ex; PCSrc_EX = pcsrc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"}, {21'd0, ctrl_now()}, 32'd0);
    check({tag, " pc"},   PC_IDEX,  32'd0);
    check({tag, " rd1"},  RD1_IDEX, 32'd0);
    check({tag, " rd2"},  RD2_IDEX, 32'd0);
    check({tag, " imm"},  Imm_IDEX, 32'd0);
    check({tag, " idx"},  {17'd0, Rs1_IDEX, Rs2_IDEX, Rd_IDEX}, 32'd0);
  endtask

  logic [31:0] exp_bypass;

  initial begin
    // ---------------- vector table ----------------
    //          instr         wb rd  data          mr rdex pc  stl bub ctrl    imm           rs1 rs2 rd  rd1       rd2
    vecs.push_back(mk(I_ADDI_X1_5, 0, 0, 32'h0,         0, 0, 0, 0, 0, C_ADDI, 32'd5,        0, 0, 1,  32'h0,  32'h0));
    vecs.push_back(mk(I_LUI,       1, 3, 32'h33,        1, 8, 0, 0, 0, C_LUI,  32'h12345000, 0, 0, 8,  32'h0,  32'h0));
    vecs.push_back(mk(I_SW,        1, 2, 32'h22,        0, 0, 0, 0, 0, C_SW,   32'd8,        1, 3, 0,  32'h0,  32'h33));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         0, 0, 0, 0, 0, C_ADD,  32'd0,        3, 2, 4,  32'h33, 32'h22));
    vecs.push_back(mk(I_SUB,       0, 0, 32'h0,         0, 0, 0, 0, 0, C_SUB,  32'd0,        3, 2, 9,  32'h33, 32'h22));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         1, 3, 0, 1, 1, C_NONE, 32'd0,        0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         1, 0, 0, 0, 0, C_ADD,  32'd0,        3, 2, 4,  32'h33, 32'h22));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         1, 2, 0, 1, 1, C_NONE, 32'd0,        0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_ADDI_X1_5, 0, 0, 32'h0,         1, 5, 0, 0, 0, C_ADDI, 32'd5,        0, 0, 1,  32'h0,  32'h0));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         1, 3, 1, 0, 1, C_NONE, 32'd0,        0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_ADD,       0, 0, 32'h0,         0, 0, 1, 0, 1, C_NONE, 32'd0,        0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_BEQ_M8,    0, 0, 32'h0,         0, 0, 0, 0, 0, C_BEQ,  32'hFFFFFFF8, 0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_BAD,       0, 0, 32'h0,         1, 3, 0, 0, 1, C_NONE, 32'd0,        0, 0, 0,  32'h0,  32'h0));
    vecs.push_back(mk(I_JAL,       0, 0, 32'h0,         0, 0, 0, 0, 0, C_JAL,  32'd16,       0, 0, 1,  32'h0,  32'h0));
    vecs.push_back(mk(I_SRAI,      0, 0, 32'h0,         0, 0, 0, 0, 0, C_SRAI, 32'h404,      3, 0, 10, 32'h33, 32'h0));
    vecs.push_back(mk(I_LW,        0, 0, 32'h0,         0, 0, 0, 0, 0, C_LW,   32'hFFFFFFFC, 2, 0, 11, 32'h22, 32'h0));
    vecs.push_back(mk(I_ADDI_X7_X0,1, 0, 32'h1234,      0, 0, 0, 0, 0, C_ADDI, 32'd0,        0, 0, 7,  32'h0,  32'h0));
    vecs.push_back(mk(I_ADDI_X7_X0,0, 0, 32'h0,         0, 0, 0, 0, 0, C_ADDI, 32'd0,        0, 0, 7,  32'h0,  32'h0));
    foreach (vecs[i]) vecs[i].pc = 32'h1000 + 32'(i) * 32'd4;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(I_ADD, 32'h40, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);   // hazard inputs during reset
    #2;
    check("reset stall", {31'd0, Stall_IF}, 32'd0);
    @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data,
            vecs[i].mem_read_ex, vecs[i].rd_ex, vecs[i].pcsrc);
      #1;
      check($sformatf("v%0d stall", i), {31'd0, Stall_IF}, {31'd0, vecs[i].exp_stall});
      @(posedge clk); #1;
      check($sformatf("v%0d ctrl", i), {21'd0, ctrl_now()}, {21'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d pc", i),  PC_IDEX, vecs[i].exp_bubble ? 32'd0 : vecs[i].pc);
      check($sformatf("v%0d imm", i), Imm_IDEX, vecs[i].exp_imm);
      check($sformatf("v%0d idx", i), {17'd0, Rs1_IDEX, Rs2_IDEX, Rd_IDEX},
            {17'd0, vecs[i].exp_rs1, vecs[i].exp_rs2, vecs[i].exp_rd});
      check($sformatf("v%0d rd1", i), RD1_IDEX, vecs[i].exp_rd1);
      check($sformatf("v%0d rd2", i), RD2_IDEX, vecs[i].exp_rd2);
    end

    // ---------------- same-cycle WB write and read of x5 ----------------
`ifdef WB_BYPASS_EN
    exp_bypass = 32'hDEADBEEF;
`else
    exp_bypass = 32'h0;
`endif
    @(negedge clk);
    drive(I_ADDI_X6_X5, 32'h2000, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    check("wb same-cycle rd1", RD1_IDEX, exp_bypass);
    check("wb same-cycle rs1", {27'd0, Rs1_IDEX}, 32'd5);
    @(negedge clk);
    drive(I_ADDI_X6_X5, 32'h2004, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    check("wb next-cycle rd1", RD1_IDEX, 32'hDEADBEEF);

    // ---------------- reset asserted mid-operation ----------------
    @(negedge clk);
    drive(I_ADD, 32'h3000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    check("pre-reset rd1", RD1_IDEX, 32'h33);
    #2;
    rst_n = 1'b0;
    drive(I_ADDI_X1_5, 32'h3004, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset ctrl", {21'd0, ctrl_now()}, {21'd0, C_ADDI});
    check("post-reset imm", Imm_IDEX, 32'd5);
    check("post-reset pc", PC_IDEX, 32'h3004);
    @(negedge clk);
    drive(I_ADD, 32'h3008, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    check("rf cleared rd1", RD1_IDEX, 32'd0);
    check("rf cleared rd2", RD2_IDEX, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 Instruc_IFID  in  32  instruction from IF/ID register; PC_IFID  in  32  its PC.
REQ-003 RegWrite_WB  in  1, Rd_WB  in  5, Result_WB  in  32  register-file write port from WB.
REQ-004 MemRead_EX  in  1, Rd_EX  in  5  load-in-EX info for hazard check; PCSrc_EX  in  1  taken branch/jump, flush.
REQ-005 Stall_IF  out  1  combinational; holds PC and IF/ID when 1.
REQ-006 PC_IDEX, RD1_IDEX, RD2_IDEX, Imm_IDEX  out  32 each  registered PC, rs1/rs2 data, immediate.
REQ-007 Rs1_IDEX, Rs2_IDEX, Rd_IDEX  out  5 each  registered register indices.
REQ-008 ALUCtrl_IDEX  out  4; ALUSrc_IDEX, MemRead_IDEX, MemWrite_IDEX, RegWrite_IDEX, MemToReg_IDEX, Branch_IDEX, Jump_IDEX  out  1 each.

Function
REQ-009 Register file 32x32; x0 reads 0 always, writes to x0 ignored; write on rising clk when RegWrite_WB=1.
REQ-010 Decode opcodes: 0110011 R-ALU, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE, 1101111 JAL, 0110111 LUI; any other opcode decodes as bubble.
REQ-011 ALUCtrl: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010; LW/SW/JAL use ADD, BEQ/BNE use SUB, LUI uses PASSB.
REQ-012 Immediate: I, S, B, J formats sign-extended from instruction bit 31 to 32 bits; U format = {inst[31:12],12'b0}; R-type Imm=0.
REQ-013 ALUSrc=1 for I-ALU, LW, SW, LUI; MemToReg=1 only for LW; RegWrite=1 for R-ALU, I-ALU, LW, JAL, LUI.
REQ-014 Load-use hazard: Stall_IF=1 iff MemRead_EX=1, Rd_EX!=0, and Rd_EX equals a source register actually used by the decoded instruction (rs2 unused by I-ALU, LW, JAL, LUI; rs1 unused by JAL, LUI).
REQ-015 ID/EX register updates every rising clk (latency 1 cycle); normal case loads decoded fields.
REQ-016 When Stall_IF=1, ID/EX loads a bubble: all control outputs 0, all data/index outputs 0.
REQ-017 When PCSrc_EX=1, ID/EX loads a bubble regardless of Stall_IF (flush beats stall); Stall_IF itself is forced 0 while PCSrc_EX=1.
REQ-018 Register file write and ID/EX capture occur on the same edge; same-cycle read of Rd_WB governed by REQ-023.

Reset
REQ-019 rst_n=0 immediately clears all ID/EX outputs to 0 and all 32 registers to 0.
REQ-020 Stall_IF is 0 during reset (inputs treated as bubble-free).
REQ-021 Reset asserted mid-operation discards any in-flight ID/EX contents; first edge after release captures current Instruc_IFID.

Configuration
REQ-022 Macro WB_BYPASS_EN selects internal write-through forwarding.
REQ-023 Defined: if RegWrite_WB=1, Rd_WB!=0 and Rd_WB equals rs1/rs2, RD1/RD2 captured = Result_WB; undefined: captured value is the pre-write register content.

Verification
REQ-024 Reset then ADDI x1,x0,5 (0x00500093) -> next cycle RegWrite_IDEX=1, ALUSrc_IDEX=1, Imm_IDEX=5, Rd_IDEX=1, ALUCtrl_IDEX=0000.
REQ-025 MemRead_EX=1, Rd_EX=3, ADD x4,x3,x2 in ID -> Stall_IF=1, next edge all ID/EX control=0; same with Rd_EX=0 -> Stall_IF=0.
REQ-026 Stall condition plus PCSrc_EX=1 same cycle -> Stall_IF=0, ID/EX bubble.
REQ-027 WB writes x5=0xDEADBEEF while ID reads rs1=x5 -> RD1_IDEX=0xDEADBEEF with WB_BYPASS_EN, old value (0) without.
REQ-028 BEQ with imm=-8 (0xFE000CE3) -> Imm_IDEX=0xFFFFFFF8, Branch_IDEX=1, RegWrite_IDEX=0; opcode 0x7F -> full bubble; write to x0 then read -> 0.
